// File: rtl/bus_memory_responder.sv
// Memory-side responder for a single-outstanding-request CPU bus, backed by a word-wide RAM.
// Optional misaligned-access trapping is enabled by defining BUS_MEMORY_RESPONDER_MISALIGN_TRAP_EN.
module bus_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_bus_data,
  input  logic [31:0] i_bus_address,
  input  logic        i_bus_DV,
  input  logic [2:0]  i_bhw,
  input  logic        i_write_notread,
  output logic [31:0] o_bus_data,
  output logic        o_bus_DV,
  output logic        o_bus_err,
  output logic        o_busy
);

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  // Handshake: a request is taken only when i_bus_DV=1 at an edge in IDLE; every accepted
  // request yields exactly one o_bus_DV cycle, and requests seen while busy are dropped.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            lane_q;
  size_e                 size_q;
  logic [31:0]           wdata_q;
  logic                  wr_q;
  logic                  trap_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [31:0] mem [0:DEPTH-1];

  size_e                 req_size;
  logic [1:0]            req_lane;
  logic                  req_trap;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  accept;

  logic                  is_idle;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [1:0]            acc_lane;
  size_e                 acc_size;
  logic [31:0]           acc_wdata;
  logic                  acc_wr;
  logic                  acc_trap;

  logic                  enter_resp;
  logic                  commit;
  logic [3:0]            be;
  logic [31:0]           wshift;
  logic [31:0]           rword;
  logic [31:0]           rdata_d;
  logic                  unused_addr;

  assign unused_addr = ^i_bus_address[31:ADDR_WIDTH+2];

  // Request decode; anything that is not a clean byte/half one-hot is a word access.
  always_comb begin
    req_size = SZ_WORD;
    if (i_bhw == 3'b001) begin
      req_size = SZ_BYTE;
    end else if (i_bhw == 3'b010) begin
      req_size = SZ_HALF;
    end
  end

  always_comb begin
    req_lane = 2'b00;
    case (req_size)
      SZ_BYTE: req_lane = i_bus_address[1:0];
      SZ_HALF: req_lane = {i_bus_address[1], 1'b0};
      default: req_lane = 2'b00;
    endcase
  end

`ifdef BUS_MEMORY_RESPONDER_MISALIGN_TRAP_EN
  assign req_trap = ((req_size == SZ_HALF) && i_bus_address[0]) ||
                    ((req_size == SZ_WORD) && (i_bus_address[1:0] != 2'b00));
`else
  assign req_trap = 1'b0;
`endif

  assign req_idx = i_bus_address[ADDR_WIDTH+1:2];
  assign accept  = (state_q == S_IDLE) && i_bus_DV;

  // With LATENCY=1 the RAM is accessed on the accepting edge, before anything is latched.
  assign is_idle   = (state_q == S_IDLE);
  assign acc_idx   = is_idle ? req_idx         : idx_q;
  assign acc_lane  = is_idle ? req_lane        : lane_q;
  assign acc_size  = is_idle ? req_size        : size_q;
  assign acc_wdata = is_idle ? i_bus_data      : wdata_q;
  assign acc_wr    = is_idle ? i_write_notread : wr_q;
  assign acc_trap  = is_idle ? req_trap        : trap_q;

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_bus_DV) begin
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_bus_DV   = (state_q == S_RESP);
    o_busy     = (state_q != S_IDLE);
    o_bus_err  = (state_q == S_RESP) && err_q;
    o_bus_data = rdata_q;
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign commit     = enter_resp && acc_wr && !acc_trap && !i_rst;

  always_comb begin
    be = 4'b1111;
    case (acc_size)
      SZ_BYTE: be = 4'b0001 << acc_lane;
      SZ_HALF: be = acc_lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign wshift = acc_wdata << {acc_lane, 3'b000};
  assign rword  = mem[acc_idx];

  always_comb begin
    rdata_d = 32'd0;
    if (!acc_wr && !acc_trap) begin
      case (acc_size)
        SZ_BYTE: rdata_d = {24'd0, rword[{acc_lane, 3'b000} +: 8]};
        SZ_HALF: rdata_d = {16'd0, rword[{acc_lane[1], 4'b0000} +: 16]};
        default: rdata_d = rword;
      endcase
    end
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[acc_idx][8*b +: 8] <= wshift[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= SZ_WORD;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      trap_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= req_idx;
      lane_q  <= req_lane;
      size_q  <= req_size;
      wdata_q <= i_bus_data;
      wr_q    <= i_write_notread;
      trap_q  <= req_trap;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= rdata_d;
      err_q   <= acc_trap;
    end
  end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: one LATENCY=2 instance and one LATENCY=1 instance
// share the request bus, selected by sel.
module tb_bus_memory_responder;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [31:0] req_data;
  logic [31:0] req_addr;
  logic        req_dv;
  logic [2:0]  req_bhw;
  logic        req_wr;

  logic [31:0] data_l2, data_l1;
  logic        dv_l2, dv_l1, err_l2, err_l1, busy_l2, busy_l1;

  logic [31:0] obs_data;
  logic        obs_dv, obs_err, obs_busy;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  bus_memory_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_l2 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_bus_data      (req_data),
    .i_bus_address   (req_addr),
    .i_bus_DV        (req_dv & ~sel),
    .i_bhw           (req_bhw),
    .i_write_notread (req_wr),
    .o_bus_data      (data_l2),
    .o_bus_DV        (dv_l2),
    .o_bus_err       (err_l2),
    .o_busy          (busy_l2)
  );

  bus_memory_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_bus_data      (req_data),
    .i_bus_address   (req_addr),
    .i_bus_DV        (req_dv & sel),
    .i_bhw           (req_bhw),
    .i_write_notread (req_wr),
    .o_bus_data      (data_l1),
    .o_bus_DV        (dv_l1),
    .o_bus_err       (err_l1),
    .o_busy          (busy_l1)
  );

  assign obs_data = sel ? data_l1 : data_l2;
  assign obs_dv   = sel ? dv_l1   : dv_l2;
  assign obs_err  = sel ? err_l1  : err_l2;
  assign obs_busy = sel ? busy_l1 : busy_l2;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full request/response on the selected instance.
  task automatic bus_txn(input string tag, input logic s, input logic wr, input logic [2:0] bhw,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int   n;
    logic seen;
    logic [31:0] exp;
    @(negedge clk);
    sel      = s;
    req_wr   = wr;
    req_bhw  = bhw;
    req_addr = addr;
    req_data = wdata;
    req_dv   = 1'b1;
    exp_q.push_back(exp_data);
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      req_dv = 1'b0;
      n++;
      if (n == 1) check_eq({tag, "_busy"}, 32'(obs_busy), 32'd1);
      if (obs_dv) seen = 1'b1;
    end
    exp = exp_q.pop_front();
    check_eq({tag, "_dv_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check_eq({tag, "_data"}, obs_data, exp);
    check_eq({tag, "_err"}, 32'(obs_err), 32'(exp_err));
    @(negedge clk);
    check_eq({tag, "_dv_fall"}, 32'(obs_dv), 32'd0);
    check_eq({tag, "_busy_fall"}, 32'(obs_busy), 32'd0);
  endtask

  initial begin
    int          pulses;
    logic [31:0] got;
    n_checks = 0;
    n_fail   = 0;
    sel      = 1'b0;
    req_data = 32'd0;
    req_addr = 32'd0;
    req_dv   = 1'b0;
    req_bhw  = 3'b100;
    req_wr   = 1'b0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_dv_l2",   32'(dv_l2),   32'd0);
    check_eq("rst_err_l2",  32'(err_l2),  32'd0);
    check_eq("rst_busy_l2", 32'(busy_l2), 32'd0);
    check_eq("rst_data_l2", data_l2,      32'd0);
    check_eq("rst_dv_l1",   32'(dv_l1),   32'd0);
    check_eq("rst_busy_l1", 32'(busy_l1), 32'd0);
    check_eq("rst_data_l1", data_l1,      32'd0);

    // Word write/read and byte/half lanes on the LATENCY=2 instance
    bus_txn("wr_word10", 1'b0, 1'b1, 3'b100, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    bus_txn("rd_word10", 1'b0, 1'b0, 3'b100, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    bus_txn("wr_word20", 1'b0, 1'b1, 3'b100, 32'h20, 32'h11223344, 32'h0, 1'b0, 2);
    bus_txn("wr_byte22", 1'b0, 1'b1, 3'b001, 32'h22, 32'h000000AA, 32'h0, 1'b0, 2);
    bus_txn("rd_word20", 1'b0, 1'b0, 3'b100, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 2);
    bus_txn("rd_half22", 1'b0, 1'b0, 3'b010, 32'h22, 32'h0, 32'h000011AA, 1'b0, 2);
    bus_txn("rd_byte23", 1'b0, 1'b0, 3'b001, 32'h23, 32'h0, 32'h00000011, 1'b0, 2);
    bus_txn("rd_byte20", 1'b0, 1'b0, 3'b001, 32'h20, 32'h0, 32'h00000044, 1'b0, 2);
    bus_txn("wr_half20", 1'b0, 1'b1, 3'b010, 32'h20, 32'hFFFFBEEF, 32'h0, 1'b0, 2);
    bus_txn("rd_word20b", 1'b0, 1'b0, 3'b100, 32'h20, 32'h0, 32'h11AABEEF, 1'b0, 2);
    bus_txn("rd_bhw011", 1'b0, 1'b0, 3'b011, 32'h20, 32'h0, 32'h11AABEEF, 1'b0, 2);
    bus_txn("rd_bhw000", 1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 32'h11AABEEF, 1'b0, 2);

    // Requests during WAIT and RESP must be dropped
    @(negedge clk);
    sel      = 1'b0;
    req_wr   = 1'b0;
    req_bhw  = 3'b100;
    req_addr = 32'h10;
    req_data = 32'h0;
    req_dv   = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    req_wr   = 1'b1;
    req_data = 32'h0;
    req_dv   = 1'b1;
    pulses   = 0;
    got      = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) req_dv = 1'b0;
      if (obs_dv) begin
        pulses++;
        got = obs_data;
      end
      @(negedge clk);
    end
    check_eq("drop_pulses", 32'(pulses), 32'd1);
    check_eq("drop_data", got, exp_q.pop_front());
    bus_txn("drop_rd10", 1'b0, 1'b0, 3'b100, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Reset during WAIT aborts a pending write
    bus_txn("init_wr30", 1'b0, 1'b1, 3'b100, 32'h30, 32'h0, 32'h0, 1'b0, 2);
    bus_txn("pre_rst_rd10", 1'b0, 1'b0, 3'b100, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    @(negedge clk);
    req_wr   = 1'b1;
    req_bhw  = 3'b100;
    req_addr = 32'h30;
    req_data = 32'h55;
    req_dv   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_dv = 1'b0;
    check_eq("mid_busy_before_rst", 32'(obs_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_dv",   32'(obs_dv),   32'd0);
    check_eq("rst_mid_busy", 32'(obs_busy), 32'd0);
    check_eq("rst_mid_data", obs_data,      32'd0);
    check_eq("rst_mid_err",  32'(obs_err),  32'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (obs_dv) pulses++;
    end
    check_eq("rst_mid_pulses", 32'(pulses), 32'd0);
    bus_txn("post_rst_rd30", 1'b0, 1'b0, 3'b100, 32'h30, 32'h0, 32'h0, 1'b0, 2);

    // Aliasing on the LATENCY=1 instance
    bus_txn("l1_wr1004", 1'b1, 1'b1, 3'b100, 32'h1004, 32'h12345678, 32'h0, 1'b0, 1);
    bus_txn("l1_rd4",    1'b1, 1'b0, 3'b100, 32'h4, 32'h0, 32'h12345678, 1'b0, 1);

    // Misaligned accesses
`ifdef BUS_MEMORY_RESPONDER_MISALIGN_TRAP_EN
    bus_txn("mis_wr21",  1'b0, 1'b1, 3'b100, 32'h21, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
    bus_txn("mis_rd20",  1'b0, 1'b0, 3'b100, 32'h20, 32'h0, 32'h11AABEEF, 1'b0, 2);
    bus_txn("mis_rdh21", 1'b0, 1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 1'b1, 2);
`else
    bus_txn("mis_wr21",  1'b0, 1'b1, 3'b100, 32'h21, 32'hFFFFFFFF, 32'h0, 1'b0, 2);
    bus_txn("mis_rd20",  1'b0, 1'b0, 3'b100, 32'h20, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    bus_txn("mis_rdh21", 1'b0, 1'b0, 3'b010, 32'h21, 32'h0, 32'h0000FFFF, 1'b0, 2);
`endif
    bus_txn("ok_rdh22",  1'b0, 1'b0, 3'b010, 32'h22, 32'h0,
`ifdef BUS_MEMORY_RESPONDER_MISALIGN_TRAP_EN
            32'h000011AA,
`else
            32'h0000FFFF,
`endif
            1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
Memory-side responder for the CPU's single-outstanding-request data/instruction bus. It accepts one request pulse with address, data, byte/half/word select and direction. After a fixed latency it returns a one-cycle data-valid pulse, carrying read data or a write acknowledge. It is backed by a word-wide RAM array and sits between the CPU bus outputs and the CPU's i_bus_data/i_bus_DV inputs.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words.
LATENCY, 2, cycles from the request-sampling edge to the edge that raises o_bus_DV; legal range 1..15.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  reset, asynchronous, active-high
i_bus_data  input  32  write data, right-justified (byte in [7:0], half in [15:0])
i_bus_address  input  32  byte address
i_bus_DV  input  1  request strobe, one cycle per request
i_bhw  input  3  access size, one-hot: 001 byte, 010 half, 100 word
i_write_notread  input  1  1 = write, 0 = read
o_bus_data  output  32  read data, right-justified, zero-extended; 0 for writes
o_bus_DV  output  1  response strobe, exactly one cycle per accepted request
o_bus_err  output  1  error flag, valid only while o_bus_DV=1
o_busy  output  1  high from acceptance until the response cycle ends

Behaviour:
- Reset (async, i_rst=1): state IDLE, wait counter 0, o_bus_DV=0, o_bus_err=0, o_bus_data=0, o_busy=0. RAM contents are not cleared.
- Reset mid-transaction aborts it: no response is produced and a pending write is NOT committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE: at an edge with i_bus_DV=1, latch address, data, bhw and write_notread. Load counter with LATENCY-1. Go to WAIT, or to RESP directly if LATENCY=1. o_busy=1 from the next cycle.
- WAIT: decrement counter each edge; at 0, go to RESP.
- Entering RESP (same edge): a write commits to the RAM under byte enables; a read registers data into o_bus_data. o_bus_DV=1 for exactly one cycle.
- RESP: next edge returns to IDLE, clears o_bus_DV and o_busy. o_bus_data holds its value until the next response.
- Back-to-back: a new request may be sampled in the cycle o_bus_DV=1 is low again (IDLE). Minimum request spacing is LATENCY+1 cycles.
- i_bus_DV while busy (WAIT/RESP): ignored and dropped, no side effects.
- Addressing is little-endian. Word index = address[ADDR_WIDTH+1:2]. Upper address bits are ignored, so the array aliases.
- Byte access: lane address[1:0]. Half access: lane address[1]. Read data is shifted down to bit 0; unused upper bits are 0. Sign extension belongs to the CPU.
- Illegal i_bhw (not one-hot) is treated as word.
- Write with byte/half touches only the selected lanes; other bytes are unchanged.
- Read of a never-written location returns X in simulation; the bench initialises the RAM before use.

Optional Feature:
Macro: BUS_MEMORY_RESPONDER_MISALIGN_TRAP_EN.
- Defined: a half access with address[0]=1, or a word access with address[1:0]!=0, is a trap. The response still occurs at normal latency, with o_bus_err=1 and o_bus_data=0. Writes are suppressed and the RAM is unchanged.
- Not defined: o_bus_err is tied 0. Misaligned low address bits are masked (half ignores bit 0, word ignores bits 1:0) and the access proceeds aligned.

Test Plan:
- Word write then read, LATENCY=2: write 0xDEADBEEF @0x10 -> o_bus_DV exactly 2 cycles after request, o_bus_data=0. Read @0x10 -> o_bus_DV after 2 cycles, o_bus_data=0xDEADBEEF, o_bus_err=0.
- Byte/half lanes: word 0x11223344 @0x20; write byte 0xAA @0x22 -> word 0x11AA3344. Read half @0x22 -> 0x000011AA. Read byte @0x23 -> 0x00000011.
- Busy drop: request read @0x10, then assert i_bus_DV one cycle later with write 0x0 @0x10 -> single o_bus_DV, read returns 0xDEADBEEF, RAM unchanged.
- Reset mid-op: write 0x55 @0x30 (old 0x0), assert i_rst during WAIT -> o_bus_DV never rises, outputs 0. A later read @0x30 returns 0x0.
- Alias/LATENCY=1: ADDR_WIDTH=10, write 0x12345678 @0x1004 -> read @0x4 returns 0x12345678, with o_bus_DV one cycle after each request.
- Misaligned word write 0xFFFFFFFF @0x21 -> with macro: o_bus_err=1, o_bus_data=0, word @0x20 unchanged. Without macro: o_bus_err=0 and word @0x20 becomes 0xFFFFFFFF.
